pe_mem_seq: RTL

//  Parametrised PE memory subsystem: NUM_EXT extrinsic RAM channels, plus ping-pong intrinsic/decision banks with host/PE swap handshake.

---
 rtl/pe_mem_pkg.sv | 21 ++
 rtl/pe_mem_seq_if.sv | 55 +++++
 rtl/pe_mem_dp_ram.sv | 34 +++
 rtl/pe_mem_seq.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pe_mem_pkg.sv
// Shared types and defaults for the PE memory subsystem: sequencer state
// encoding, default widths and the per-channel bit-slice helper.
package pe_mem_pkg;

  localparam int DEF_MESSAGE_WIDTH  = 5;
  localparam int DEF_DECISION_WIDTH = 1;
  localparam int DEF_ADDR_WIDTH     = 8;
  localparam int DEF_NUM_EXT        = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

  // LSB position of channel ch inside a packed multi-channel message bus
  function automatic int ch_lsb(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/pe_mem_seq_if.sv
// Bus between the decoder control/PE side (master) and pe_mem_seq (slave):
// sweep control, read stream, writeback, host load/readback and bank swap.
interface pe_mem_seq_if #(
  parameter int MESSAGE_WIDTH  = pe_mem_pkg::DEF_MESSAGE_WIDTH,
  parameter int DECISION_WIDTH = pe_mem_pkg::DEF_DECISION_WIDTH,
  parameter int ADDR_WIDTH     = pe_mem_pkg::DEF_ADDR_WIDTH,
  parameter int NUM_EXT        = pe_mem_pkg::DEF_NUM_EXT
);

  logic                              start;
  logic [ADDR_WIDTH:0]               len;
  logic                              stall;
  logic                              busy;
  logic                              done;
  logic                              rd_valid;
  logic [ADDR_WIDTH-1:0]             rd_addr;
  logic [NUM_EXT*MESSAGE_WIDTH-1:0]  rd_ext;
  logic [MESSAGE_WIDTH-1:0]          rd_int;
  logic [NUM_EXT-1:0]                wb_we;
  logic [ADDR_WIDTH-1:0]             wb_addr;
  logic [NUM_EXT*MESSAGE_WIDTH-1:0]  wb_data;
  logic                              dec_we;
  logic [ADDR_WIDTH-1:0]             dec_addr;
  logic [DECISION_WIDTH-1:0]         dec_data;
  logic                              ld_we;
  logic [ADDR_WIDTH-1:0]             ld_addr;
  logic [MESSAGE_WIDTH-1:0]          ld_data;
  logic [DECISION_WIDTH-1:0]         host_dec;
  logic                              swap_req;
  logic                              swap_ack;
  logic                              bank_sel;

  modport master (
    output start, len, stall,
    input  busy, done, rd_valid, rd_addr, rd_ext, rd_int,
    output wb_we, wb_addr, wb_data,
    output dec_we, dec_addr, dec_data,
    output ld_we, ld_addr, ld_data,
    input  host_dec,
    output swap_req,
    input  swap_ack, bank_sel
  );

  modport slave (
    input  start, len, stall,
    output busy, done, rd_valid, rd_addr, rd_ext, rd_int,
    input  wb_we, wb_addr, wb_data,
    input  dec_we, dec_addr, dec_data,
    input  ld_we, ld_addr, ld_data,
    output host_dec,
    input  swap_req,
    output swap_ack, bank_sel
  );

endinterface

// File: rtl/pe_mem_dp_ram.sv
// One-write/one-read synchronous RAM with a resettable read register.
// WRITE_FIRST forwards same-address write data to the read port.
module pe_mem_dp_ram #(
  parameter int WIDTH       = 5,
  parameter int ADDR_WIDTH  = 8,
  parameter bit WRITE_FIRST = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [1 << ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // read register holds its value while re is low so a stalled stream stays put
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      if (WRITE_FIRST && we && (waddr == raddr)) rdata <= wdata;
      else                                       rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/pe_mem_seq.sv
// PE memory subsystem: extrinsic RAMs, ping-pong intrinsic/decision banks and
// the sweep sequencer. Define PE_MEM_BYPASS_EN for write-first extrinsic reads.
//
//   state | meaning
//   IDLE  | waiting for start; bank swaps are applied here
//   RUN   | issuing read addresses 0..len-1
//   DRAIN | last read data on the outputs, waiting for it to be consumed
module pe_mem_seq
  import pe_mem_pkg::*;
#(
  parameter int MESSAGE_WIDTH  = DEF_MESSAGE_WIDTH,
  parameter int DECISION_WIDTH = DEF_DECISION_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int NUM_EXT        = DEF_NUM_EXT
) (
  input  logic        clk,
  input  logic        rst,
  pe_mem_seq_if.slave bus
);

  localparam int CNT_W = ADDR_WIDTH + 1;

`ifdef PE_MEM_BYPASS_EN
  localparam bit EXT_WRITE_FIRST = 1'b1;
`else
  localparam bit EXT_WRITE_FIRST = 1'b0;
`endif

  seq_state_t                       state;
  logic [CNT_W-1:0]                 cnt;
  logic [CNT_W-1:0]                 len_q;
  logic [CNT_W-1:0]                 launch_len;
  logic                             start_pend;
  logic                             busy_q;
  logic                             done_q;
  logic                             rd_valid_q;
  logic [ADDR_WIDTH-1:0]            rd_addr_q;
  logic                             swap_ack_q;
  logic                             bank_sel_q;
  logic [ADDR_WIDTH-1:0]            rd_ptr;
  logic                             issue;
  logic                             swap_ok;
  logic                             accept_start;
  logic                             launch_go;
  logic [MESSAGE_WIDTH-1:0]         ext_q [NUM_EXT];
  logic [MESSAGE_WIDTH-1:0]         int_q [2];
  logic [DECISION_WIDTH-1:0]        dec_q [2];
  logic [NUM_EXT*MESSAGE_WIDTH-1:0] rd_ext_w;

  assign rd_ptr       = cnt[ADDR_WIDTH-1:0];
  assign issue        = (state == RUN) && !bus.stall;
  // swap_ack_q guard keeps a still-held request from swapping twice
  assign swap_ok      = (state == IDLE) && !start_pend && bus.swap_req && !swap_ack_q;
  assign accept_start = (state == IDLE) && !busy_q && !start_pend && bus.start;
  // start together with a swap is parked one cycle so the sweep sees the new bank
  assign launch_go    = start_pend || (accept_start && !swap_ok);
  assign launch_len   = start_pend ? len_q : bus.len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      len_q      <= '0;
      start_pend <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      swap_ack_q <= 1'b0;
      bank_sel_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      swap_ack_q <= 1'b0;
      unique case (state)
        IDLE: begin
          busy_q <= 1'b0;
          if (swap_ok) begin
            bank_sel_q <= ~bank_sel_q;
            swap_ack_q <= 1'b1;
          end
          if (start_pend) start_pend <= 1'b0;
          if (accept_start && swap_ok) begin
            start_pend <= 1'b1;
            len_q      <= bus.len;
          end
          if (launch_go) begin
            busy_q <= 1'b1;
            if (launch_len == '0) begin
              done_q <= 1'b1;
            end else begin
              state <= RUN;
              cnt   <= '0;
              len_q <= launch_len;
            end
          end
        end
        RUN: begin
          if (!bus.stall) begin
            rd_valid_q <= 1'b1;
            rd_addr_q  <= rd_ptr;
            cnt        <= cnt + 1'b1;
            if (cnt == len_q - 1'b1) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!bus.stall) begin
            rd_valid_q <= 1'b0;
            done_q     <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_EXT; k++) begin : g_ext
    pe_mem_dp_ram #(
      .WIDTH       (MESSAGE_WIDTH),
      .ADDR_WIDTH  (ADDR_WIDTH),
      .WRITE_FIRST (EXT_WRITE_FIRST)
    ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (bus.wb_we[k]),
      .waddr (bus.wb_addr),
      .wdata (bus.wb_data[ch_lsb(k, MESSAGE_WIDTH) +: MESSAGE_WIDTH]),
      .re    (issue),
      .raddr (rd_ptr),
      .rdata (ext_q[k])
    );
  end

  // bank b faces the host whenever the PE is on the other bank
  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic host_side;
    assign host_side = (b == 0) ? bank_sel_q : ~bank_sel_q;

    pe_mem_dp_ram #(
      .WIDTH       (MESSAGE_WIDTH),
      .ADDR_WIDTH  (ADDR_WIDTH),
      .WRITE_FIRST (1'b0)
    ) u_int (
      .clk   (clk),
      .rst   (rst),
      .we    (bus.ld_we && host_side),
      .waddr (bus.ld_addr),
      .wdata (bus.ld_data),
      .re    (issue),
      .raddr (rd_ptr),
      .rdata (int_q[b])
    );

    pe_mem_dp_ram #(
      .WIDTH       (DECISION_WIDTH),
      .ADDR_WIDTH  (ADDR_WIDTH),
      .WRITE_FIRST (1'b0)
    ) u_dec (
      .clk   (clk),
      .rst   (rst),
      .we    (bus.dec_we && !host_side),
      .waddr (bus.dec_addr),
      .wdata (bus.dec_data),
      .re    (1'b1),
      .raddr (bus.ld_addr),
      .rdata (dec_q[b])
    );
  end

  always_comb begin
    rd_ext_w = '0;
    for (int k = 0; k < NUM_EXT; k++) begin
      rd_ext_w[ch_lsb(k, MESSAGE_WIDTH) +: MESSAGE_WIDTH] = ext_q[k];
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.rd_ext   = rd_ext_w;
  assign bus.rd_int   = bank_sel_q ? int_q[1] : int_q[0];
  assign bus.host_dec = bank_sel_q ? dec_q[0] : dec_q[1];
  assign bus.swap_ack = swap_ack_q;
  assign bus.bank_sel = bank_sel_q;

endmodule
